// File: rtl/dff_pipe_hs_pkg.sv
// Shared constants and helpers for the elastic DFF pipeline chain.
package dff_pipe_hs_pkg;

    localparam int DFF_PIPE_MAX_DEPTH = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data register pair of the elastic chain, with its load/clear logic.
module dff_pipe_stage #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             rdy_o
);

    assign rdy_o = !vld_o || dn_ready;

    // Stalled stages keep dat_o untouched so held output stays stable.
    always_ff @(posedge clk) begin
        if (clear) begin
            vld_o <= 1'b0;
            dat_o <= RST_DATA;
        end else if (up_valid && rdy_o) begin
            vld_o <= 1'b1;
            dat_o <= up_data;
        end else if (rdy_o) begin
            vld_o <= 1'b0;
        end
    end

endmodule

// File: rtl/dff_pipe_hs.sv
// Elastic pipeline register chain: DEPTH valid/ready stages with flush and occupancy count.
module dff_pipe_hs
    import dff_pipe_hs_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RST_DATA = '0,
    localparam int              CNT_W    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("dff_pipe_hs: DEPTH must be in 1..16");
    end

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] dn_rdy;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             clear;
    logic             acc_in;
    logic             acc_out;

    assign clear = rst || flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Downstream ready is the unrolled ready chain: any bubble further down, or out_ready.
        if (i == DEPTH - 1) begin : g_last
            assign dn_rdy[i] = out_ready;
        end else begin : g_mid
            assign dn_rdy[i] = out_ready || !(&vld[DEPTH-1:i+1]);
        end

        if (i == 0) begin : g_first
            dff_pipe_stage #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_stage (
                .clk      (clk),
                .clear    (clear),
                .up_valid (in_valid && !clear),
                .up_data  (in_data),
                .dn_ready (dn_rdy[i]),
                .vld_o    (vld[i]),
                .dat_o    (dat[i]),
                .rdy_o    (rdy[i])
            );
        end else begin : g_next
            dff_pipe_stage #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_stage (
                .clk      (clk),
                .clear    (clear),
                .up_valid (vld[i-1]),
                .up_data  (dat[i-1]),
                .dn_ready (dn_rdy[i]),
                .vld_o    (vld[i]),
                .dat_o    (dat[i]),
                .rdy_o    (rdy[i])
            );
        end
    end

    assign in_ready  = rdy[0] && !clear;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(acc_in) - CNT_W'(acc_out);
        end
    end

`ifndef SYNTHESIS
    a_count_matches_vld : assert property (@(posedge clk) disable iff (rst)
        count == CNT_W'($countones(vld)));
`endif

endmodule

// File: tb/tb_dff_pipe_hs.sv
// Self-checking bench for dff_pipe_hs: directed DEPTH=3 scenarios plus a random DEPTH=1 scoreboard run.
module tb_dff_pipe_hs;

    localparam logic [31:0] RST_D = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        flush2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_data2;
    logic [0:0]  count2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dff_pipe_hs #(.WIDTH(32), .DEPTH(3), .RST_DATA(RST_D)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    dff_pipe_hs #(.WIDTH(32), .DEPTH(1), .RST_DATA(RST_D)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .count(count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        tests_run++;
        if (out_data !== RST_D) begin tests_failed++; $display("FAIL rst_out_data got %h exp %h", out_data, RST_D); end
        tests_run++;
        if (int'(count) !== 0) begin tests_failed++; $display("FAIL rst_count got %0d exp 0", count); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready_during got %0b exp 0", in_ready); end
        tests_run++;
        if (out_valid2 !== 1'b0 || out_data2 !== RST_D) begin
            tests_failed++; $display("FAIL rst_d1_out got v=%0b d=%h exp v=0 d=%h", out_valid2, out_data2, RST_D);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready_after got %0b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        int exp_cnt [6] = '{1, 2, 3, 3, 2, 1};
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd1;
        #1;
        for (int c = 1; c <= 6; c++) begin
            tests_run++;
            if (in_valid && in_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_in_ready c=%0d got %0b exp 1", c, in_ready); end
            tick();
            if (c < 4) in_data = 32'(c + 1);
            else in_valid = 1'b0;
            tests_run++;
            if (out_valid !== (c >= 3)) begin tests_failed++; $display("FAIL t1_out_valid c=%0d got %0b exp %0b", c, out_valid, c >= 3); end
            if (c >= 3) begin
                tests_run++;
                if (out_data !== 32'(c - 2)) begin tests_failed++; $display("FAIL t1_out_data c=%0d got %0d exp %0d", c, out_data, c - 2); end
            end
            tests_run++;
            if (int'(count) !== exp_cnt[c-1]) begin tests_failed++; $display("FAIL t1_count c=%0d got %0d exp %0d", c, count, exp_cnt[c-1]); end
        end
        repeat (2) tick();
        tests_run++;
        if (int'(count) !== 0) begin tests_failed++; $display("FAIL t1_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_full_stall();
        logic [31:0] drain [3] = '{32'hB, 32'hC, 32'hD};
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        in_data = 32'hC; tick();
        in_data = 32'hD;
        #1;
        tests_run++;
        if (int'(count) !== 3) begin tests_failed++; $display("FAIL t2_full_count got %0d exp 3", count); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_full_in_ready got %0b exp 0", in_ready); end
        repeat (2) tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin tests_failed++; $display("FAIL t2_hold got v=%0b d=%h exp v=1 d=a", out_valid, out_data); end
        tests_run++;
        if (int'(count) !== 3) begin tests_failed++; $display("FAIL t2_hold_count got %0d exp 3", count); end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL t2_passthru_ready got %0b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (int'(count) !== 3) begin tests_failed++; $display("FAIL t2_swap_count got %0d exp 3", count); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== drain[k]) begin
                tests_failed++; $display("FAIL t2_drain k=%0d got v=%0b d=%h exp v=1 d=%h", k, out_valid, out_data, drain[k]);
            end
            tick();
        end
        tests_run++;
        if (int'(count) !== 0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL t2_empty got cnt=%0d v=%0b exp cnt=0 v=0", count, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        tests_run++;
        if (int'(count) !== 2) begin tests_failed++; $display("FAIL t3_pre_count got %0d exp 2", count); end
        flush = 1'b1;
        in_data = 32'h55;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL t3_flush_in_ready got %0b exp 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (int'(count) !== 0 || out_valid !== 1'b0 || out_data !== RST_D) begin
            tests_failed++; $display("FAIL t3_after got cnt=%0d v=%0b d=%h exp cnt=0 v=0 d=%h", count, out_valid, out_data, RST_D);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t3_no_emerge k=%0d got v=%0b d=%h exp v=0", k, out_valid, out_data); end
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h41; tick();
        in_data = 32'h42; tick();
        rst = 1'b1;
        in_data = 32'h43;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_rst_in_ready got %0b exp 0", in_ready); end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== RST_D || int'(count) !== 0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_after got v=%0b d=%h cnt=%0d rdy=%0b exp v=0 d=%h cnt=0 rdy=1", out_valid, out_data, count, in_ready, RST_D);
        end
        in_valid = 1'b1;
        in_data = 32'h99;
        for (int k = 1; k <= 3; k++) begin
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== (k == 3)) begin tests_failed++; $display("FAIL t4_latency k=%0d got v=%0b exp %0b", k, out_valid, k == 3); end
        end
        tests_run++;
        if (out_data !== 32'h99) begin tests_failed++; $display("FAIL t4_data got %h exp 99", out_data); end
        tick();
    endtask

    task automatic test_bubble();
        logic exp_v [7] = '{0, 0, 1, 0, 1, 0, 0};
        logic [31:0] exp_d [7] = '{0, 0, 32'h61, 0, 32'h63, 0, 0};
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h61;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            if (k == 2) begin in_valid = 1'b1; in_data = 32'h63; end
            if (k == 3) in_valid = 1'b0;
            tests_run++;
            if (out_valid !== exp_v[k-1]) begin tests_failed++; $display("FAIL t6_out_valid k=%0d got %0b exp %0b", k, out_valid, exp_v[k-1]); end
            if (exp_v[k-1]) begin
                tests_run++;
                if (out_data !== exp_d[k-1]) begin tests_failed++; $display("FAIL t6_out_data k=%0d got %h exp %h", k, out_data, exp_d[k-1]); end
            end
            tests_run++;
            if (int'(count) > 2) begin tests_failed++; $display("FAIL t6_count k=%0d got %0d exp <=2", k, count); end
        end
    endtask

    task automatic test_random_depth1();
        int q[$];
        logic last_acc = 1'b0;
        logic exp_rdy;
        logic acc_in;
        logic acc_out;
        for (int n = 0; n < 10000; n++) begin
            flush2 = ($urandom_range(0, 99) == 0);
            out_ready2 = 1'($urandom_range(0, 1));
            if (!in_valid2 || last_acc) begin
                in_valid2 = 1'($urandom_range(0, 1));
                in_data2 = $urandom;
            end
            #1;
            exp_rdy = !flush2 && (q.size() == 0 || out_ready2);
            tests_run++;
            if (in_ready2 !== exp_rdy) begin tests_failed++; $display("FAIL t5_in_ready n=%0d got %0b exp %0b", n, in_ready2, exp_rdy); end
            acc_in = in_valid2 && exp_rdy;
            acc_out = (q.size() > 0) && out_ready2;
            tick();
            if (acc_out) void'(q.pop_front());
            if (flush2) q.delete();
            else if (acc_in) q.push_back(int'(in_data2));
            last_acc = acc_in;
            tests_run++;
            if (int'(count2) !== q.size()) begin tests_failed++; $display("FAIL t5_count n=%0d got %0d exp %0d", n, count2, q.size()); end
            tests_run++;
            if (out_valid2 !== (q.size() > 0)) begin tests_failed++; $display("FAIL t5_out_valid n=%0d got %0b exp %0b", n, out_valid2, q.size() > 0); end
            if (q.size() > 0) begin
                tests_run++;
                if (out_data2 !== 32'(q[0])) begin tests_failed++; $display("FAIL t5_out_data n=%0d got %h exp %h", n, out_data2, 32'(q[0])); end
            end
        end
        flush2 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_flush();
        test_mid_reset();
        test_bubble();
        test_random_depth1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
